dst_data_unpack: RTL and testbench

Destination-side data unpacker for the SDMA datapath. It accepts full 512-bit words on a ready/valid input and replays each word to the destination port as 8-bit, 32-bit or 512-bit beats, least-significant slice first. Its data-width modes match the source-side buffer, so a transfer packed at one width can be unpacked at any supported width. It holds one word and accepts the next word on the same cycle the last beat leaves, so throughput in 512b mode is one word per cycle.

---
 rtl/dst_data_unpack.sv | 98 +++++++++
 tb/tb_dst_data_unpack.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/dst_data_unpack.sv
// Destination-side unpacker: holds one 512-bit word and replays it as 8b, 32b
// or 512b beats, least-significant slice first, with back-to-back word reload.
module dst_data_unpack (
    input  logic         clk,
    input  logic         rst,
    input  logic         mode_vld,
    input  logic [3:0]   mode,
    output logic         mode_err,
    input  logic         din_vld,
    input  logic [511:0] din,
    output logic         din_rdy,
    output logic         dout_vld,
    output logic [511:0] dout,
    input  logic         dout_rdy
);

    typedef enum logic {
        EMPTY,
        SEND
    } state_t;

    typedef enum logic [1:0] {
        MODE_8B   = 2'd0,
        MODE_32B  = 2'd1,
        MODE_512B = 2'd2
    } width_t;

    state_t       state;
    width_t       mode_r;
    logic [511:0] data_buf;
    logic [5:0]   cnt;
    logic         last;
    logic         mode_legal;

    assign mode_legal = (mode <= 4'd2);

    always_comb begin
        last = 1'b0;
        case (mode_r)
            MODE_8B:  last = (cnt == 6'd63);
            MODE_32B: last = (cnt == 6'd15);
            default:  last = (cnt == 6'd0);
        endcase
    end

    always_comb begin
        dout = '0;
        case (mode_r)
            MODE_8B:  dout[7:0]  = data_buf[{cnt, 3'b000} +: 8];
            MODE_32B: dout[31:0] = data_buf[{cnt[3:0], 5'b00000} +: 32];
            default:  dout       = data_buf;
        endcase
    end

    assign dout_vld = (state == SEND);
    assign din_rdy  = (state == EMPTY) || ((state == SEND) && last && dout_rdy);

    // mode_r is written on the same edge a word is accepted, so that word
    // is already replayed at the newly selected width.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= EMPTY;
            data_buf <= '0;
            cnt      <= '0;
            mode_r   <= MODE_512B;
            mode_err <= 1'b0;
        end else begin
            mode_err <= mode_vld && (!mode_legal || (state == SEND));
            if (mode_vld && mode_legal && (state == EMPTY))
                mode_r <= width_t'(mode[1:0]);

            case (state)
                EMPTY: begin
                    if (din_vld) begin
                        data_buf <= din;
                        cnt      <= '0;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (dout_rdy) begin
                        if (!last) begin
                            cnt <= cnt + 6'd1;
                        end else if (din_vld) begin
                            data_buf <= din;
                            cnt      <= '0;
                        end else begin
                            cnt   <= '0;
                            state <= EMPTY;
                        end
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_dst_data_unpack.sv
// Directed self-checking bench for dst_data_unpack.
module tb_dst_data_unpack;

    logic         clk;
    logic         rst;
    logic         mode_vld;
    logic [3:0]   mode;
    logic         mode_err;
    logic         din_vld;
    logic [511:0] din;
    logic         din_rdy;
    logic         dout_vld;
    logic [511:0] dout;
    logic         dout_rdy;

    int n_checks;
    int n_errors;

    dst_data_unpack dut (
        .clk      (clk),
        .rst      (rst),
        .mode_vld (mode_vld),
        .mode     (mode),
        .mode_err (mode_err),
        .din_vld  (din_vld),
        .din      (din),
        .din_rdy  (din_rdy),
        .dout_vld (dout_vld),
        .dout     (dout),
        .dout_rdy (dout_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [511:0] w_bytes, w_rev, w0, w1, w_single;
    logic [511:0] w512 [10];

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1; mode_vld = 1'b0; mode = '0; din_vld = 1'b0; din = '0; dout_rdy = 1'b0;

        for (int i = 0; i < 64; i++) begin
            w_bytes[8*i +: 8] = 8'(i);
            w_rev[8*i +: 8]   = 8'(255 - i);
        end
        for (int j = 0; j < 16; j++) begin
            w0[32*j +: 32]       = 32'hA000_0000 | 32'(j);
            w1[32*j +: 32]       = 32'hB000_0000 | 32'(j);
            w_single[32*j +: 32] = 32'h5A5A_0000 | 32'(j * 3);
        end
        for (int k = 0; k < 10; k++)
            for (int j = 0; j < 16; j++)
                w512[k][32*j +: 32] = (32'h0101_0101 * 32'(k + 1)) ^ 32'(j);

        #1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_dout_vld", {511'b0, dout_vld}, 512'd0);
        check("rst_dout", dout, 512'd0);
        check("rst_din_rdy", {511'b0, din_rdy}, 512'd1);
        check("rst_mode_err", {511'b0, mode_err}, 512'd0);

        // 8b mode, byte i = i
        mode_vld = 1'b1; mode = 4'd0; din_vld = 1'b1; din = w_bytes; dout_rdy = 1'b1;
        #1;
        check("b8_accept_rdy", {511'b0, din_rdy}, 512'd1);
        tick();
        mode_vld = 1'b0; din_vld = 1'b0;
        for (int i = 0; i < 64; i++) begin
            #1;
            check("b8_vld", {511'b0, dout_vld}, 512'd1);
            check("b8_dout", dout, 512'(i));
            check("b8_din_rdy", {511'b0, din_rdy}, {511'b0, (i == 63)});
            if (i == 0) check("b8_no_err", {511'b0, mode_err}, 512'd0);
            tick();
        end
        #1;
        check("b8_end_vld", {511'b0, dout_vld}, 512'd0);
        check("b8_end_rdy", {511'b0, din_rdy}, 512'd1);

        // 32b mode, two words back-to-back
        mode_vld = 1'b1; mode = 4'd1; din_vld = 1'b1; din = w0;
        tick();
        mode_vld = 1'b0; din = w1;
        for (int i = 0; i < 32; i++) begin
            #1;
            check("b32_vld", {511'b0, dout_vld}, 512'd1);
            check("b32_dout", dout, {480'b0, (i < 16) ? 32'hA000_0000 | 32'(i) : 32'hB000_0000 | 32'(i - 16)});
            check("b32_din_rdy", {511'b0, din_rdy}, {511'b0, (i == 15 || i == 31)});
            tick();
            if (i == 15) din_vld = 1'b0;
        end
        #1;
        check("b32_end_vld", {511'b0, dout_vld}, 512'd0);

        // 512b mode, ten words streamed
        for (int k = 0; k <= 10; k++) begin
            mode_vld = (k == 0); mode = 4'd2;
            din_vld  = (k < 10);
            din      = (k < 10) ? w512[k] : '0;
            #1;
            check("b512_din_rdy", {511'b0, din_rdy}, 512'd1);
            check("b512_vld", {511'b0, dout_vld}, {511'b0, (k > 0)});
            if (k > 0) check("b512_dout", dout, w512[k-1]);
            tick();
        end
        din_vld = 1'b0; mode_vld = 1'b0;
        #1;
        check("b512_end_vld", {511'b0, dout_vld}, 512'd0);

        // 8b mode with dout_rdy pattern 1,0,0,1,...
        mode_vld = 1'b1; mode = 4'd0; din_vld = 1'b1; din = w_rev; dout_rdy = 1'b0;
        tick();
        mode_vld = 1'b0; din_vld = 1'b0;
        begin
            int idx;
            int t;
            idx = 0;
            t = 0;
            while (idx < 64 && t < 400) begin
                dout_rdy = ((t % 3) == 0);
                #1;
                check("stall_vld", {511'b0, dout_vld}, 512'd1);
                check("stall_dout", dout, 512'(255 - idx));
                check("stall_din_rdy", {511'b0, din_rdy}, {511'b0, (idx == 63 && dout_rdy)});
                tick();
                if (dout_rdy) idx++;
                t++;
            end
            check("stall_budget", 512'(idx), 512'd64);
        end
        dout_rdy = 1'b1;
        #1;
        check("stall_end_vld", {511'b0, dout_vld}, 512'd0);

        // mode change attempt during 32b SEND
        mode_vld = 1'b1; mode = 4'd1; din_vld = 1'b1; din = w0;
        tick();
        mode_vld = 1'b0; din_vld = 1'b0;
        for (int i = 0; i < 16; i++) begin
            mode_vld = (i == 3); mode = 4'd0;
            #1;
            check("merr_dout", dout, {480'b0, 32'hA000_0000 | 32'(i)});
            check("merr_pulse", {511'b0, mode_err}, {511'b0, (i == 4)});
            tick();
        end
        mode_vld = 1'b0;
        #1;
        check("merr_end_vld", {511'b0, dout_vld}, 512'd0);

        // reset in the middle of an 8b word
        mode_vld = 1'b1; mode = 4'd0; din_vld = 1'b1; din = w_bytes;
        tick();
        mode_vld = 1'b0; din_vld = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        #1;
        check("rstmid_beat7", dout, 512'd7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("rstmid_vld", {511'b0, dout_vld}, 512'd0);
        check("rstmid_dout", dout, 512'd0);
        check("rstmid_rdy", {511'b0, din_rdy}, 512'd1);

        // reserved mode in EMPTY, then the next word goes out as one 512b beat
        mode_vld = 1'b1; mode = 4'd5;
        tick();
        mode_vld = 1'b0;
        #1;
        check("resv_err", {511'b0, mode_err}, 512'd1);
        din_vld = 1'b1; din = w_single;
        tick();
        din_vld = 1'b0;
        #1;
        check("resv_err_clear", {511'b0, mode_err}, 512'd0);
        check("single_vld", {511'b0, dout_vld}, 512'd1);
        check("single_dout", dout, w_single);
        check("single_rdy", {511'b0, din_rdy}, 512'd1);
        tick();
        #1;
        check("single_end_vld", {511'b0, dout_vld}, 512'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
